// File: rtl/cache_pkg.sv
// Shared types and constants for the cache controller: FSM state encoding,
// address field widths and a word-select helper for 128-bit lines.
package cache_pkg;

    localparam int TAG_W          = 3;
    localparam int INDEX_W        = 10;
    localparam int OFFSET_W       = 2;
    localparam int WORDS_PER_LINE = 4;
    localparam int WORD_BITS      = 32;
    localparam int LINE_BITS      = WORD_BITS * WORDS_PER_LINE;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_WAIT,
        REFILL,
        RESP
    } state_t;

    // Offset 0 is the least-significant word of the line.
    function automatic logic [WORD_BITS-1:0] select_word(
        input logic [LINE_BITS-1:0] line,
        input logic [OFFSET_W-1:0]  off
    );
        logic [WORD_BITS-1:0] word;
        word = '0;
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            if (int'(off) == i) begin
                word = line[i*WORD_BITS +: WORD_BITS];
            end
        end
        return word;
    endfunction

endpackage

// File: rtl/cache_controller_if.sv
// Bus bundle between the controller and its environment (CPU load port,
// cache array, memory model, statistics). The master view belongs to the
// controller; the slave view to whatever surrounds it.
interface cache_controller_if #(
    parameter int ADDR_W = 15,
    parameter int WORD_W = 32,
    parameter int LINE_W = 128,
    parameter int CNT_W  = 16
);
    // CPU load port
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ready;
    logic              cpu_valid;
    logic [WORD_W-1:0] cpu_data;
    // Cache array
    logic [ADDR_W-1:0] cache_addr;
    logic              cache_hit;
    logic [WORD_W-1:0] cache_data;
    logic              cache_fill_en;
    logic [LINE_W-1:0] cache_fill_data;
    // Main memory
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [LINE_W-1:0] mem_data;
    // Statistics
    logic              clear_stats;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    modport master (
        input  cpu_req, cpu_addr, cache_hit, cache_data, mem_ack, mem_data, clear_stats,
        output cpu_ready, cpu_valid, cpu_data, cache_addr, cache_fill_en, cache_fill_data,
               mem_req, mem_addr, hit_count, miss_count
    );

    modport slave (
        output cpu_req, cpu_addr, cache_hit, cache_data, mem_ack, mem_data, clear_stats,
        input  cpu_ready, cpu_valid, cpu_data, cache_addr, cache_fill_en, cache_fill_data,
               mem_req, mem_addr, hit_count, miss_count
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at its maximum value; clear beats increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] count_q, count_d;

    // Next count: clear first, otherwise increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/cache_controller.sv
// Direct-mapped read-only cache sequencer: probes the cache for one CPU word
// read at a time, refills a 128-bit line from memory on a miss, returns the
// word, and keeps saturating hit/miss statistics.
module cache_controller
    import cache_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int WORD_W = 32,
    parameter int LINE_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    cache_controller_if.master bus
);
    localparam int BLK_W = TAG_W + INDEX_W;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic              fill_en_q, fill_en_d;
    logic              cpu_valid_q, cpu_valid_d;
    logic [WORD_W-1:0] cpu_data_q, cpu_data_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              hit_inc, miss_inc;

    // State and datapath registers; reset returns everything to a quiet IDLE,
    // which also drops an outstanding mem_req at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            mem_req_q   <= 1'b0;
            fill_en_q   <= 1'b0;
            cpu_valid_q <= 1'b0;
            cpu_data_q  <= '0;
            line_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_req_q   <= mem_req_d;
            fill_en_q   <= fill_en_d;
            cpu_valid_q <= cpu_valid_d;
            cpu_data_q  <= cpu_data_d;
            line_q      <= line_d;
        end
    end

    // Next-state decode; mem_ack only matters while waiting for memory.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (bus.cpu_req) state_d = LOOKUP;
            LOOKUP:   state_d = bus.cache_hit ? RESP : MEM_WAIT;
            MEM_WAIT: if (bus.mem_ack) state_d = REFILL;
            REFILL:   state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Registered-output next values; strobes default low, data holds.
    always_comb begin
        addr_d      = addr_q;
        mem_addr_d  = mem_addr_q;
        mem_req_d   = mem_req_q;
        fill_en_d   = 1'b0;
        cpu_valid_d = 1'b0;
        cpu_data_d  = cpu_data_q;
        line_d      = line_q;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req) addr_d = bus.cpu_addr;
            end
            LOOKUP: begin
                if (bus.cache_hit) begin
                    cpu_data_d  = bus.cache_data;
                    cpu_valid_d = 1'b1;
                    hit_inc     = 1'b1;
                end else begin
                    mem_addr_d = {addr_q[OFFSET_W +: BLK_W], {OFFSET_W{1'b0}}};
                    mem_req_d  = 1'b1;
                    miss_inc   = 1'b1;
                end
            end
            MEM_WAIT: begin
                // The fill strobe is raised here so it is high throughout REFILL.
                if (bus.mem_ack) begin
                    line_d    = bus.mem_data;
                    mem_req_d = 1'b0;
                    fill_en_d = 1'b1;
                end
            end
            REFILL: begin
                // Return the word from the captured line rather than re-probing.
                cpu_data_d  = select_word(line_q, addr_q[OFFSET_W-1:0]);
                cpu_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc_i   (hit_inc),
        .clr_i   (bus.clear_stats),
        .count_o (bus.hit_count)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc_i   (miss_inc),
        .clr_i   (bus.clear_stats),
        .count_o (bus.miss_count)
    );

    assign bus.cpu_ready       = (state_q == IDLE);
    assign bus.cpu_valid       = cpu_valid_q;
    assign bus.cpu_data        = cpu_data_q;
    assign bus.cache_addr      = addr_q;
    assign bus.cache_fill_en   = fill_en_q;
    assign bus.cache_fill_data = line_q;
    assign bus.mem_req         = mem_req_q;
    assign bus.mem_addr        = mem_addr_q;
endmodule
